ysyx_040729_clint: RTL and testbench

- Core-local interruptor. It is the source side of the timer/software interrupt lines that the trap-cause logic consumes.
- Holds the 64-bit mtime counter, the mtimecmp compare register and the msip bit.
- Exposes them over a single-beat memory-mapped request/response port used by the LSU.
- Drives tmr_irq and sft_irq into the core's exception path.

---
 rtl/ysyx_040729_clint.sv | 111 +++++++++++
 tb/tb_ysyx_040729_clint.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040729_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a single-beat bus port.
// Optional YSYX_040729_CLINT_DBG_HALT_EN adds dbg_halt to freeze mtime.
module ysyx_040729_clint #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int TICK_DIV   = 1
) (
`ifdef YSYX_040729_CLINT_DBG_HALT_EN
    input  logic                    dbg_halt,
`endif
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_wen,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    tmr_irq,
    output logic                    sft_irq
);

    localparam int MW = DATA_WIDTH / 8;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [ADDR_WIDTH-1:0] A_MSIP = ADDR_WIDTH'(16'h0000);
    localparam logic [ADDR_WIDTH-1:0] A_CMP  = ADDR_WIDTH'(16'h4000);
    localparam logic [ADDR_WIDTH-1:0] A_TIME = ADDR_WIDTH'(16'hBFF8);

    logic [DATA_WIDTH-1:0] mtime;
    logic [DATA_WIDTH-1:0] mtimecmp;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] merged;
    logic [PW-1:0]         presc;
    logic [ADDR_WIDTH-1:0] off;
    logic msip;
    logic halt;
    logic tick;
    logic accept;
    logic wr;
    logic hit_msip;
    logic hit_cmp;
    logic hit_time;
    logic unused_bits;

`ifdef YSYX_040729_CLINT_DBG_HALT_EN
    assign halt = dbg_halt;
`else
    assign halt = 1'b0;
`endif

    assign unused_bits = ^req_addr[2:0];
    assign off       = {req_addr[ADDR_WIDTH-1:3], 3'b000};
    assign hit_msip  = (off == A_MSIP);
    assign hit_cmp   = (off == A_CMP);
    assign hit_time  = (off == A_TIME);
    assign req_ready = !resp_valid | resp_ready;
    assign accept    = req_valid & req_ready;
    assign wr        = accept & req_wen;
    assign tick      = !halt & (presc == P_LAST);

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            hit_msip: rd_val = {{(DATA_WIDTH-1){1'b0}}, msip};
            hit_cmp:  rd_val = mtimecmp;
            hit_time: rd_val = mtime;
            default:  rd_val = '0;
        endcase
    end

    // Unmasked bytes keep the addressed register's current contents.
    always_comb begin
        merged = rd_val;
        for (int i = 0; i < MW; i++) begin
            if (req_wmask[i]) merged[i*8 +: 8] = req_wdata[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            mtime      <= '0;
            mtimecmp   <= '1;
            msip       <= 1'b0;
            tmr_irq    <= 1'b0;
            sft_irq    <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (!halt) presc <= tick ? '0 : presc + PW'(1);
            // A bus write to mtime overrides the tick in the same cycle.
            if (wr & hit_time) mtime <= merged;
            else if (tick)     mtime <= mtime + DATA_WIDTH'(1);
            if (wr & hit_cmp)  mtimecmp <= merged;
            if (wr & hit_msip) msip <= merged[0];
            tmr_irq <= (mtime >= mtimecmp);
            sft_irq <= msip;
            if (accept) begin
                resp_valid <= 1'b1;
                resp_rdata <= req_wen ? '0 : rd_val;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_040729_clint.sv
// Directed bench for ysyx_040729_clint: dut0 uses TICK_DIV=1, dut4 TICK_DIV=4.
// Halt checks are compiled when YSYX_040729_CLINT_DBG_HALT_EN is defined.
module tb_ysyx_040729_clint;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] req_valid, req_ready, req_wen;
    logic [1:0] resp_valid, resp_ready, tmr_irq, sft_irq;
    logic [15:0] req_addr [2];
    logic [63:0] req_wdata [2];
    logic [7:0]  req_wmask [2];
    logic [63:0] resp_rdata [2];
`ifdef YSYX_040729_CLINT_DBG_HALT_EN
    logic [1:0] dbg_halt;
`endif
    int checks = 0;
    int failures = 0;
    int cyc;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    ysyx_040729_clint #(.TICK_DIV(1)) dut0 (
`ifdef YSYX_040729_CLINT_DBG_HALT_EN
        .dbg_halt(dbg_halt[0]),
`endif
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_wen(req_wen[0]),
        .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]),
        .tmr_irq(tmr_irq[0]), .sft_irq(sft_irq[0])
    );

    ysyx_040729_clint #(.TICK_DIV(4)) dut4 (
`ifdef YSYX_040729_CLINT_DBG_HALT_EN
        .dbg_halt(dbg_halt[1]),
`endif
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_wen(req_wen[1]),
        .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]),
        .tmr_irq(tmr_irq[1]), .sft_irq(sft_irq[1])
    );

    // One transaction: accept on the next edge, response consumed on the one after.
    task automatic xfer(input int d, input logic wen, input logic [15:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask,
                        output logic rv, output logic [63:0] rd,
                        output logic [1:0] irq);
        req_valid[d] = 1'b1;
        req_wen[d]   = wen;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wmask[d] = wmask;
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        rv  = resp_valid[d];
        rd  = resp_rdata[d];
        irq = {tmr_irq[d], sft_irq[d]};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({resp_valid[0], req_ready[0], tmr_irq[0], sft_irq[0]} !== 4'b0100 ||
            resp_rdata[0] !== 64'h0) begin
            failures++;
            $display("FAIL reset_outputs got v/r/t/s=%b%b%b%b rdata=%h exp 0100 rdata=0",
                     resp_valid[0], req_ready[0], tmr_irq[0], sft_irq[0], resp_rdata[0]);
        end
        req_valid[0] = 1'b1;
        req_wen[0]   = 1'b0;
        req_addr[0]  = 16'hBFF8;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 64'h0) begin
            failures++;
            $display("FAIL reset_mtime got v=%b rdata=%h exp v=1 rdata=0",
                     resp_valid[0], resp_rdata[0]);
        end
        req_addr[0] = 16'h4000;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        checks++;
        if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL reset_mtimecmp got v=%b rdata=%h exp v=1 rdata=all-ones",
                     resp_valid[0], resp_rdata[0]);
        end
        checks++;
        if (tmr_irq[0] !== 1'b0 || sft_irq[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_irqs got t=%b s=%b exp 0 0", tmr_irq[0], sft_irq[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timer();
        logic rv;
        logic [63:0] rd;
        logic [1:0] irq;
        int first;
        xfer(0, 1'b1, 16'hBFF8, 64'h0, 8'hFF, rv, rd, irq);
        xfer(0, 1'b1, 16'h4000, 64'd20, 8'hFF, rv, rd, irq);
        checks++;
        if (rv !== 1'b1 || rd !== 64'h0) begin
            failures++;
            $display("FAIL write_resp got v=%b rdata=%h exp v=1 rdata=0", rv, rd);
        end
        first = -1;
        for (int k = 3; k <= 40; k++) begin
            if (tmr_irq[0] === 1'b1) begin
                first = k;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (first != 21) begin
            failures++;
            $display("FAIL tmr_rise got cycle=%0d exp 21", first);
        end
        xfer(0, 1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rv, rd, irq);
        checks++;
        if (irq[1] !== 1'b1 || tmr_irq[0] !== 1'b0) begin
            failures++;
            $display("FAIL tmr_fall got at_accept=%b after=%b exp 1 0", irq[1], tmr_irq[0]);
        end
    endtask

    task automatic test_msip();
        logic rv;
        logic [63:0] rd;
        logic [1:0] irq;
        xfer(0, 1'b1, 16'h0000, 64'hFFFF, 8'hFF, rv, rd, irq);
        checks++;
        if (irq[0] !== 1'b0 || sft_irq[0] !== 1'b1) begin
            failures++;
            $display("FAIL sft_rise got at_accept=%b after=%b exp 0 1", irq[0], sft_irq[0]);
        end
        xfer(0, 1'b0, 16'h0000, 64'h0, 8'h00, rv, rd, irq);
        checks++;
        if (rd !== 64'h1) begin
            failures++;
            $display("FAIL msip_read got %h exp 1", rd);
        end
        xfer(0, 1'b0, 16'h0004, 64'h0, 8'h00, rv, rd, irq);
        checks++;
        if (rd !== 64'h1) begin
            failures++;
            $display("FAIL msip_low_bits got %h exp 1", rd);
        end
        xfer(0, 1'b1, 16'h0000, 64'h0, 8'hFF, rv, rd, irq);
        checks++;
        if (sft_irq[0] !== 1'b0) begin
            failures++;
            $display("FAIL sft_fall got %b exp 0", sft_irq[0]);
        end
    endtask

    task automatic test_unmapped();
        logic rv;
        logic [63:0] rd;
        logic [1:0] irq;
        xfer(0, 1'b1, 16'h0100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rv, rd, irq);
        xfer(0, 1'b0, 16'h0100, 64'h0, 8'h00, rv, rd, irq);
        checks++;
        if (rv !== 1'b1 || rd !== 64'h0) begin
            failures++;
            $display("FAIL unmapped got v=%b rdata=%h exp v=1 rdata=0", rv, rd);
        end
    endtask

    task automatic test_mtime_write();
        logic rv;
        logic [63:0] rd;
        logic [1:0] irq;
        xfer(0, 1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rv, rd, irq);
        xfer(0, 1'b0, 16'hBFF8, 64'h0, 8'h00, rv, rd, irq);
        checks++;
        if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL mtime_max got %h exp ffffffffffffffff", rd);
        end
        xfer(0, 1'b0, 16'hBFF8, 64'h0, 8'h00, rv, rd, irq);
        checks++;
        if (rd !== 64'h1) begin
            failures++;
            $display("FAIL mtime_wrap got %h exp 1", rd);
        end
        xfer(0, 1'b1, 16'hBFF8, 64'hAAAA_BBBB_0000_0000, 8'hFF, rv, rd, irq);
        xfer(0, 1'b1, 16'hBFF8, 64'hDEAD_BEEF_1234_5678, 8'h0F, rv, rd, irq);
        xfer(0, 1'b0, 16'hBFF8, 64'h0, 8'h00, rv, rd, irq);
        checks++;
        if (rd !== 64'hAAAA_BBBB_1234_5679) begin
            failures++;
            $display("FAIL mtime_partial got %h exp aaaabbbb12345679", rd);
        end
    endtask

    task automatic test_backpressure();
        logic rv;
        logic [63:0] rd;
        logic [1:0] irq;
        xfer(0, 1'b1, 16'h0000, 64'h1, 8'h01, rv, rd, irq);
        req_valid[0]  = 1'b1;
        req_wen[0]    = 1'b0;
        req_addr[0]   = 16'h4000;
        resp_ready[0] = 1'b0;
        @(posedge clk); #1;
        req_addr[0] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (resp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 ||
                resp_rdata[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                failures++;
                $display("FAIL stall_hold%0d got v=%b rdy=%b rdata=%h exp v=1 rdy=0 rdata=all-ones",
                         i, resp_valid[0], req_ready[0], resp_rdata[0]);
            end
            @(posedge clk); #1;
        end
        resp_ready[0] = 1'b1;
        #1;
        checks++;
        if (req_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got rdy=%b exp 1", req_ready[0]);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        checks++;
        if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 64'h1) begin
            failures++;
            $display("FAIL stall_second got v=%b rdata=%h exp v=1 rdata=1",
                     resp_valid[0], resp_rdata[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (resp_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL stall_drain got v=%b exp 0", resp_valid[0]);
        end
        xfer(0, 1'b1, 16'h0000, 64'h0, 8'h01, rv, rd, irq);
    endtask

    task automatic test_back_to_back();
        logic rv;
        logic [63:0] rd;
        logic [1:0] irq;
        logic [63:0] exp_rd [4];
        logic [3:0] exp_wen;
        exp_rd  = '{64'd101, 64'd102, 64'd0, 64'd500};
        exp_wen = 4'b0100;
        xfer(0, 1'b1, 16'hBFF8, 64'd100, 8'hFF, rv, rd, irq);
        req_valid[0] = 1'b1;
        req_addr[0]  = 16'hBFF8;
        req_wmask[0] = 8'hFF;
        req_wdata[0] = 64'd500;
        for (int i = 0; i < 4; i++) begin
            req_wen[0] = exp_wen[i];
            @(posedge clk); #1;
            checks++;
            if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== exp_rd[i]) begin
                failures++;
                $display("FAIL b2b_%0d got v=%b rdata=%h exp v=1 rdata=%h",
                         i, resp_valid[0], resp_rdata[0], exp_rd[i]);
            end
        end
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_tick_collision();
        logic [63:0] exp_rd [3];
        logic [2:0] found;
        int n;
        exp_rd = '{64'd1000, 64'd1000, 64'd1001};
        n = 0;
        while (cyc % 4 != 3 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (cyc % 4 != 3) begin
            failures++;
            $display("FAIL div4_phase got cyc=%0d exp cyc%%4=3", cyc);
        end
        resp_ready[1] = 1'b1;
        req_valid[1]  = 1'b1;
        req_wen[1]    = 1'b1;
        req_addr[1]   = 16'hBFF8;
        req_wdata[1]  = 64'd1000;
        req_wmask[1]  = 8'hFF;
        @(posedge clk); #1;
        req_wen[1] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        checks++;
        if (resp_rdata[1] !== exp_rd[0]) begin
            failures++;
            $display("FAIL div4_collide got %h exp %h", resp_rdata[1], exp_rd[0]);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        found = '0;
        for (int i = 1; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_rdata[1] !== exp_rd[i]) begin
                failures++;
                $display("FAIL div4_read%0d got %h exp %h", i, resp_rdata[1], exp_rd[i]);
            end
        end
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
    endtask

`ifdef YSYX_040729_CLINT_DBG_HALT_EN
    task automatic test_dbg_halt();
        logic rv;
        logic [63:0] rd;
        logic [1:0] irq;
        dbg_halt[0] = 1'b1;
        xfer(0, 1'b1, 16'hBFF8, 64'd77, 8'hFF, rv, rd, irq);
        repeat (10) @(posedge clk);
        #1;
        xfer(0, 1'b0, 16'hBFF8, 64'h0, 8'h00, rv, rd, irq);
        checks++;
        if (rd !== 64'd77) begin
            failures++;
            $display("FAIL dbg_halt got %h exp 77", rd);
        end
        dbg_halt[0] = 1'b0;
        xfer(0, 1'b0, 16'hBFF8, 64'h0, 8'h00, rv, rd, irq);
        xfer(0, 1'b0, 16'hBFF8, 64'h0, 8'h00, rv, rd, irq);
        checks++;
        if (rd !== 64'd79) begin
            failures++;
            $display("FAIL dbg_resume got %h exp 79", rd);
        end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_wen    = '0;
        resp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_wmask[i] = '0;
        end
`ifdef YSYX_040729_CLINT_DBG_HALT_EN
        dbg_halt = '0;
`endif
        test_reset();
        test_timer();
        test_msip();
        test_unmapped();
        test_mtime_write();
        test_backpressure();
        test_back_to_back();
        test_tick_collision();
`ifdef YSYX_040729_CLINT_DBG_HALT_EN
        test_dbg_halt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
